// File: rtl/sofm_ctrl.sv
// Sequencer for the SOFM search/update datapath: iterations x inputs x groups x dims.
// Optional SOFM_CTRL_PERF_EN adds busy-cycle and stall-cycle counters.
module sofm_ctrl #(
  parameter int LANES     = 8,
  parameter int DRAIN_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_len,
  input  logic [15:0] i_dim,
  input  logic [15:0] i_ninput_max,
  input  logic [15:0] i_nitr_max,
  input  logic        i_stall,
  input  logic        i_update,
  output logic [1:0]  o_state,
  output logic [15:0] o_ndim,
  output logic [15:0] o_ninput,
  output logic [15:0] o_nitr,
  output logic [15:0] o_itr,
  output logic [7:0]  o_xi,
  output logic [7:0]  o_xi_1,
  output logic [15:0] o_raddr,
  output logic        o_we,
  output logic [15:0] o_waddr,
  output logic        o_flush,
  output logic        o_busy,
`ifdef SOFM_CTRL_PERF_EN
  output logic [31:0] o_cyc_cnt,
  output logic [31:0] o_stall_cnt,
`endif
  output logic        o_done
);
  localparam int LG = $clog2(LANES);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_SWEEP, S_DRAIN, S_FLUSH, S_DONE} state_t;
  typedef struct packed {
    logic [15:0] dim;
    logic [15:0] nin_max;
    logic [15:0] nitr_max;
    logic [15:0] g_last;
  } cfg_t;

  state_t        state, state_nx;
  cfg_t          cfg;
  logic [15:0]   ndim, grp, raddr, ninput, nitr;
  logic [DW-1:0] drain_cnt;
  logic [1:0]    vld_pipe;
  logic [15:0]   waddr_q;

  // group count from the incoming edge length, captured with the rest of the config
  logic [8:0]  edge_len;
  logic [17:0] sq, g_cnt;
  assign edge_len = {1'b0, i_len} + 9'd1;
  assign sq       = 18'(edge_len) * 18'(edge_len);
  assign g_cnt    = (sq + 18'(LANES - 1)) >> LG;

  logic sweeping, adv, sweep_last, drain_last, last_in, last_itr;
  assign sweeping   = (state == S_SWEEP) || (state == S_FLUSH);
  assign adv        = sweeping & ~i_stall;
  assign sweep_last = (grp == cfg.g_last) && (ndim == cfg.dim);
  assign drain_last = (drain_cnt == DW'(DRAIN_CYC - 1));
  assign last_in    = (ninput == cfg.nin_max - 16'd1);
  assign last_itr   = (nitr == cfg.nitr_max - 16'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_start) state_nx = S_INIT;
      S_INIT:  state_nx = S_SWEEP;
      S_SWEEP: if (adv && sweep_last) state_nx = S_DRAIN;
      S_DRAIN: if (drain_last) state_nx = (last_in && last_itr) ? S_FLUSH : S_INIT;
      S_FLUSH: if (adv && sweep_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    o_state = 2'd0;
    o_busy  = 1'b0;
    o_flush = 1'b0;
    o_done  = 1'b0;
    case (state)
      S_INIT:  begin o_state = 2'd1; o_busy = 1'b1; end
      S_SWEEP: begin o_state = 2'd2; o_busy = 1'b1; end
      S_DRAIN: begin o_state = 2'd3; o_busy = 1'b1; end
      S_FLUSH: begin o_state = 2'd2; o_busy = 1'b1; o_flush = 1'b1; end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cfg       <= '0;
      ndim      <= '0;
      grp       <= '0;
      raddr     <= '0;
      ninput    <= '0;
      nitr      <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          cfg       <= '{dim: i_dim, nin_max: i_ninput_max, nitr_max: i_nitr_max,
                         g_last: 16'(g_cnt - 18'd1)};
          ndim      <= '0;
          grp       <= '0;
          raddr     <= '0;
          ninput    <= '0;
          nitr      <= '0;
          drain_cnt <= '0;
        end
        S_SWEEP, S_FLUSH: if (!i_stall) begin
          // wrap everything at sweep end so the next sweep starts from address 0
          if (sweep_last) begin
            ndim  <= '0;
            grp   <= '0;
            raddr <= '0;
          end else begin
            raddr <= raddr + 16'd1;
            if (ndim == cfg.dim) begin
              ndim <= '0;
              grp  <= grp + 16'd1;
            end else begin
              ndim <= ndim + 16'd1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_last) begin
            drain_cnt <= '0;
            if (!last_in) begin
              ninput <= ninput + 16'd1;
            end else if (!last_itr) begin
              ninput <= '0;
              nitr   <= nitr + 16'd1;
            end
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // first input of the first iteration has no prior winner to update
  assign vld_pipe[0] = i_update & adv & ~((nitr == '0) && (ninput == '0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe[1] <= 1'b0;
      waddr_q     <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      waddr_q     <= raddr;
    end
  end

`ifdef SOFM_CTRL_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cyc_cnt   <= '0;
      o_stall_cnt <= '0;
    end else if (state == S_IDLE && i_start) begin
      o_cyc_cnt   <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (o_busy)             o_cyc_cnt   <= o_cyc_cnt + 32'd1;
      if (sweeping & i_stall) o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

  assign o_ndim   = ndim;
  assign o_ninput = ninput;
  assign o_nitr   = nitr;
  assign o_itr    = nitr;
  assign o_xi     = ninput[7:0];
  assign o_xi_1   = (ninput != '0)       ? 8'(ninput - 16'd1) :
                    (cfg.nin_max == '0)  ? 8'd0 : 8'(cfg.nin_max - 16'd1);
  assign o_raddr  = raddr;
  assign o_we     = vld_pipe[1];
  assign o_waddr  = waddr_q;
endmodule

// File: tb/tb_sofm_ctrl.sv
// Directed vector bench for sofm_ctrl: run-length, write count/addresses, stall, reset and restart cases.
module tb_sofm_ctrl;
  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_stall, i_update;
  logic [7:0]  i_len;
  logic [15:0] i_dim, i_ninput_max, i_nitr_max;
  logic [1:0]  o_state;
  logic [15:0] o_ndim, o_ninput, o_nitr, o_itr, o_raddr, o_waddr;
  logic [7:0]  o_xi, o_xi_1;
  logic        o_we, o_flush, o_busy, o_done;
`ifdef SOFM_CTRL_PERF_EN
  logic [31:0] o_cyc_cnt, o_stall_cnt;
`endif

  always #5 i_clk = ~i_clk;

  sofm_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len), .i_dim(i_dim),
    .i_ninput_max(i_ninput_max), .i_nitr_max(i_nitr_max), .i_stall(i_stall),
    .i_update(i_update), .o_state(o_state), .o_ndim(o_ndim), .o_ninput(o_ninput),
    .o_nitr(o_nitr), .o_itr(o_itr), .o_xi(o_xi), .o_xi_1(o_xi_1), .o_raddr(o_raddr),
    .o_we(o_we), .o_waddr(o_waddr), .o_flush(o_flush), .o_busy(o_busy),
`ifdef SOFM_CTRL_PERF_EN
    .o_cyc_cnt(o_cyc_cnt), .o_stall_cnt(o_stall_cnt),
`endif
    .o_done(o_done)
  );

  typedef struct {
    int len, dim, nin, nitr;
    int stall_at, stall_n, restart;
    int exp_busy, exp_we;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int r_busy, r_we, r_done, r_werr, r_berr, r_serr, r_ierr, nlog;
  logic [1:0]  st_log[64];
  logic [15:0] itr_log[64];
  logic        fl_log[64];
  logic [7:0]  xi_log[64], xi1_log[64];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive_cfg(input vec_t v);
    i_len        = v.len[7:0];
    i_dim        = v.dim[15:0];
    i_ninput_max = v.nin[15:0];
    i_nitr_max   = v.nitr[15:0];
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, g, s;
    logic prev_stall;
    logic [15:0] prev_raddr;
    g = ((v.len + 1) * (v.len + 1) + 7) / 8;
    s = g * (v.dim + 1);
    r_busy = 0; r_we = 0; r_done = 0; r_werr = 0; r_berr = 0; r_serr = 0; r_ierr = 0; nlog = 0;
    @(negedge i_clk);
    drive_cfg(v);
    i_update = 1'b1; i_stall = 1'b0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    cyc = 0; prev_stall = 1'b0; prev_raddr = '0;
    while (cyc < 2000) begin
      if (o_busy) r_busy++;
      if (o_done) r_done++;
      if (o_we) begin
        if (o_waddr != 16'(r_we % s)) r_werr++;
        r_we++;
      end
      if (o_ndim > v.dim || o_ninput >= v.nin || o_nitr >= v.nitr) r_berr++;
      if (prev_stall && (o_raddr != prev_raddr || o_we)) r_serr++;
      if (nlog < 64) begin
        st_log[nlog] = o_state; itr_log[nlog] = o_itr; fl_log[nlog] = o_flush;
        xi_log[nlog] = o_xi; xi1_log[nlog] = o_xi_1;
        nlog++;
      end
      if (o_done) break;
      i_stall    = (cyc >= v.stall_at) && (cyc < v.stall_at + v.stall_n);
      prev_stall = i_stall;
      prev_raddr = o_raddr;
      i_start    = (v.restart != 0) && (cyc == 5);
      @(negedge i_clk);
      cyc++;
    end
    i_stall = 1'b0;
    i_start = (v.restart != 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (o_done) r_done++;
      if (o_busy || o_state != 2'd0) r_ierr++;
    end
  endtask

  vec_t vecs[7];
  int   t3_err;
  int   t3_exp[14];

  initial begin
    vecs[0] = '{len:3, dim:3, nin:2, nitr:1, stall_at:-1, stall_n:0, restart:0, exp_busy:30,  exp_we:16};
    vecs[1] = '{len:0, dim:0, nin:1, nitr:3, stall_at:-1, stall_n:0, restart:0, exp_busy:13,  exp_we:3};
    vecs[2] = '{len:3, dim:3, nin:2, nitr:1, stall_at:14, stall_n:5, restart:0, exp_busy:35,  exp_we:16};
    vecs[3] = '{len:7, dim:1, nin:3, nitr:2, stall_at:-1, stall_n:0, restart:0, exp_busy:130, exp_we:96};
    vecs[4] = '{len:2, dim:0, nin:1, nitr:1, stall_at:-1, stall_n:0, restart:0, exp_busy:7,   exp_we:0};
    vecs[5] = '{len:4, dim:2, nin:1, nitr:2, stall_at:-1, stall_n:0, restart:0, exp_busy:42,  exp_we:24};
    vecs[6] = '{len:3, dim:3, nin:2, nitr:1, stall_at:-1, stall_n:0, restart:1, exp_busy:30,  exp_we:16};
    t3_exp = '{1, 2, 3, 3, 1, 2, 3, 3, 1, 2, 3, 3, 2, 0};

    i_rst = 1'b1; i_start = 1'b0; i_stall = 1'b0; i_update = 1'b0;
    drive_cfg(vecs[0]);
    repeat (3) @(negedge i_clk);
    check("rst_state", o_state, 0);
    check("rst_outs", int'({o_busy, o_done, o_we, o_flush}), 0);
    check("rst_cnt", int'(o_ndim | o_ninput | o_nitr | o_itr | o_raddr | o_waddr), 0);
    check("rst_xi", int'({o_xi, o_xi_1}), 0);
    i_rst = 1'b0;

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      check($sformatf("v%0d_busy", i),  r_busy, vecs[i].exp_busy);
      check($sformatf("v%0d_we", i),    r_we,   vecs[i].exp_we);
      check($sformatf("v%0d_done", i),  r_done, 1);
      check($sformatf("v%0d_waddr", i), r_werr, 0);
      check($sformatf("v%0d_bound", i), r_berr, 0);
      check($sformatf("v%0d_stall", i), r_serr, 0);
      check($sformatf("v%0d_idle", i),  r_ierr, 0);
      if (i == 0) begin
        check("t1_xi_in0",  xi_log[0],   0);
        check("t1_xi1_in0", xi1_log[0],  1);
        check("t1_xi_in1",  xi_log[11],  1);
        check("t1_xi1_in1", xi1_log[11], 0);
      end
      if (i == 1) begin
        t3_err = 0;
        for (int k = 0; k < 14; k++) if (int'(st_log[k]) != t3_exp[k]) t3_err++;
        check("t3_states", t3_err, 0);
        check("t3_itr0", itr_log[0], 0);
        check("t3_itr1", itr_log[4], 1);
        check("t3_itr2", itr_log[8], 2);
        check("t3_flush", fl_log[12], 1);
      end
      if (i == 4) check("nin1_xi1", xi1_log[0], 0);
    end

    // reset asserted in the 12th busy cycle of a T1 run
    @(negedge i_clk);
    drive_cfg(vecs[0]);
    i_update = 1'b1; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (11) @(negedge i_clk);
    check("t5_busy_pre", o_busy, 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("t5_state", o_state, 0);
    check("t5_outs", int'({o_busy, o_done, o_we, o_flush}), 0);
    check("t5_cnt", int'(o_ndim | o_ninput | o_nitr | o_raddr | o_waddr), 0);
    run_vec(vecs[0]);
    check("t5_rerun_busy", r_busy, 30);
    check("t5_rerun_done", r_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
